// File: rtl/width_gather.sv
// Narrow-to-wide gather: packs width1-bit beats into width2-bit words, LSB slice first,
// with one registered output word and zero-padded early flush.
module width_gather #(
    parameter int width1 = 2,
    parameter int width2 = 8,
    parameter int beats  = 4,
    parameter int cnt_w  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [width1-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [width2-1:0] out_data,
    output logic [cnt_w-1:0]  out_beats,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [cnt_w-1:0] full_c = cnt_w'(beats);
    localparam logic [cnt_w-1:0] last_c = cnt_w'(beats - 1);

    logic [width2-1:0] acc_r;
    logic [width2-1:0] acc_next_s;
    logic [cnt_w-1:0]  cnt_r;
    logic [cnt_w-1:0]  cnt_inc_s;
    logic [cnt_w-1:0]  held_r;
    logic [cnt_w-1:0]  word_beats_s;
    logic [width2-1:0] out_data_r;
    logic [cnt_w-1:0]  out_beats_r;
    logic              out_valid_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              slot_free_s;
    logic              flush_take_s;
    logic              complete_s;

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_beats = out_beats_r;
    assign out_valid = out_valid_r;

    // Handshake and completion decisions, all derived from registers plus this cycle's inputs.
    always_comb begin
        in_ready_s   = !reset && (cnt_r < full_c);
        accept_s     = in_valid && in_ready_s;
        slot_free_s  = !out_valid_r || out_ready;
        cnt_inc_s    = cnt_r + {{(cnt_w-1){1'b0}}, accept_s};
        flush_take_s = flush && (cnt_r < full_c) && ((cnt_r != {cnt_w{1'b0}}) || accept_s);
        complete_s   = (accept_s && (cnt_r == last_c)) || (cnt_r == full_c) || flush_take_s;
        // A stalled word (possibly a flushed partial) reports the count latched when it completed.
        word_beats_s = (cnt_r == full_c) ? held_r : cnt_inc_s;
    end

    // Accumulator with this cycle's beat merged into its slot.
    always_comb begin
        acc_next_s = acc_r;
        for (int i = 0; i < beats; i++) begin
            acc_next_s[i*width1 +: width1] = (accept_s && (cnt_r == cnt_w'(i)))
                                           ? in_data : acc_r[i*width1 +: width1];
        end
    end

    // Collect beats, hand complete words to the output register, or park them while it is busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r       <= {width2{1'b0}};
            cnt_r       <= {cnt_w{1'b0}};
            held_r      <= {cnt_w{1'b0}};
            out_data_r  <= {width2{1'b0}};
            out_beats_r <= {cnt_w{1'b0}};
            out_valid_r <= 1'b0;
        end else if (complete_s && slot_free_s) begin
            acc_r       <= {width2{1'b0}};
            cnt_r       <= {cnt_w{1'b0}};
            out_data_r  <= acc_next_s;
            out_beats_r <= word_beats_s;
            out_valid_r <= 1'b1;
        end else if (complete_s) begin
            acc_r       <= acc_next_s;
            cnt_r       <= full_c;
            held_r      <= word_beats_s;
        end else begin
            acc_r       <= acc_next_s;
            cnt_r       <= cnt_inc_s;
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_width_gather.sv
// Directed bench for width_gather: queue-based word model checked every cycle,
// plus literal expectations and a second instance with overridden widths.
module tb_width_gather;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, flush, out_ready, in_ready, out_valid;
    logic [1:0] in_data;
    logic [7:0] out_data;
    logic [2:0] out_beats;

    logic [3:0] d2_data;
    logic       d2_valid, d2_ready, d2_out_valid;
    logic [7:0] d2_out_data;
    logic [2:0] d2_out_beats;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    width_gather dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_beats(out_beats), .out_valid(out_valid), .out_ready(out_ready)
    );

    width_gather #(.width1(4), .width2(8), .beats(2), .cnt_w(3)) dut2 (
        .clk(clk), .reset(reset), .in_data(d2_data), .in_valid(d2_valid),
        .in_ready(d2_ready), .flush(1'b0), .out_data(d2_out_data),
        .out_beats(d2_out_beats), .out_valid(d2_out_valid), .out_ready(1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: beats of the word being collected, oldest first.
    int         mq[$];
    bit         m_stall, m_ov;
    logic [7:0] m_od;
    int         m_ob;
    bit         t_acc, t_free, t_flush, t_done;

    function automatic bit m_ready();
        return !reset && !m_stall && (mq.size() < 4);
    endfunction

    function automatic logic [7:0] pack();
        logic [7:0] w = 8'h00;
        foreach (mq[i]) w = w | (8'(mq[i]) << (2 * i));
        return w;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_stall = 1'b0; m_ov = 1'b0; m_od = 8'h00; m_ob = 0;
        end else begin
            t_acc  = in_valid && m_ready();
            t_free = !m_ov || out_ready;
            if (t_acc) mq.push_back(int'(in_data));
            t_flush = flush && !m_stall && (mq.size() > 0);
            t_done  = m_stall || (mq.size() == 4) || t_flush;
            if (t_done && t_free) begin
                m_od = pack(); m_ob = mq.size(); m_ov = 1'b1;
                mq.delete(); m_stall = 1'b0;
            end else if (t_done) begin
                m_stall = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready",  32'(in_ready),  32'(m_ready()));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("out_data",  32'(out_data),  32'(m_od));
            check("out_beats", 32'(out_beats), 32'(m_ob));
        end
    end

    task automatic step(input logic [1:0] d, input logic v, input logic f);
        in_data = d; in_valid = v; flush = f;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 2'b00; flush = 1'b0; out_ready = 1'b1;
        d2_data = 4'h0; d2_valid = 1'b0;
        @(posedge clk); #1;
        armed = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        step(2'b00, 1'b0, 1'b0);
        reset = 1'b0; #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_data",  32'(out_data),  32'h00);
        check("post_rst_beats", 32'(out_beats), 32'd0);
        check("post_rst_ready", 32'(in_ready),  32'd1);

        // Back-to-back words.
        step(2'b01, 1'b1, 1'b0); step(2'b10, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0); step(2'b00, 1'b1, 1'b0);
        check("w1_valid", 32'(out_valid), 32'd1);
        check("w1_data",  32'(out_data),  32'h39);
        check("w1_beats", 32'(out_beats), 32'd4);
        step(2'b00, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0); step(2'b10, 1'b1, 1'b0);
        check("w2_gap", 32'(out_valid), 32'd0);
        step(2'b11, 1'b1, 1'b0);
        check("w2_data", 32'(out_data), 32'hE4);
        step(2'b00, 1'b0, 1'b0);

        // Backpressure: second word stalls until the slot frees.
        out_ready = 1'b0;
        step(2'b01, 1'b1, 1'b0); step(2'b10, 1'b1, 1'b0); step(2'b11, 1'b1, 1'b0); step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0); step(2'b10, 1'b1, 1'b0); step(2'b11, 1'b1, 1'b0);
        check("bp_hold", 32'(out_data), 32'h39);
        check("bp_ready", 32'(in_ready), 32'd0);
        step(2'b00, 1'b0, 1'b0);
        check("bp_stable", 32'(out_data), 32'h39);
        out_ready = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        check("bp_next", 32'(out_data), 32'hE4);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        step(2'b00, 1'b0, 1'b0);

        // Flush alone, empty flush, flush with same-cycle beat.
        step(2'b11, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0); step(2'b00, 1'b0, 1'b1);
        check("fl_data",  32'(out_data),  32'h07);
        check("fl_beats", 32'(out_beats), 32'd2);
        step(2'b00, 1'b0, 1'b1);
        check("fl_empty", 32'(out_valid), 32'd0);
        step(2'b11, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0); step(2'b10, 1'b1, 1'b1);
        check("fl3_data",  32'(out_data),  32'h27);
        check("fl3_beats", 32'(out_beats), 32'd3);

        // Flush while the slot is busy parks the partial word.
        out_ready = 1'b0;
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0); step(2'b10, 1'b1, 1'b1);
        check("flst_ready", 32'(in_ready), 32'd0);
        step(2'b11, 1'b1, 1'b1);
        out_ready = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        check("flst_data",  32'(out_data),  32'h09);
        check("flst_beats", 32'(out_beats), 32'd2);
        step(2'b00, 1'b0, 1'b0);

        // Reset mid-word discards partial beats.
        step(2'b01, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0);
        reset = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        step(2'b00, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0); step(2'b10, 1'b1, 1'b0);
        check("mid_rst_quiet", 32'(out_valid), 32'd0);
        step(2'b11, 1'b1, 1'b0);
        check("mid_rst_data",  32'(out_data),  32'hE4);
        check("mid_rst_beats", 32'(out_beats), 32'd4);
        step(2'b00, 1'b0, 1'b0);

        // Overridden geometry: 4-bit beats, 2 per word.
        d2_data = 4'hA; d2_valid = 1'b1;
        @(posedge clk); #1;
        check("p4_quiet", 32'(d2_out_valid), 32'd0);
        d2_data = 4'h5;
        @(posedge clk); #1;
        d2_valid = 1'b0;
        check("p4_valid", 32'(d2_out_valid), 32'd1);
        check("p4_data",  32'(d2_out_data),  32'h5A);
        check("p4_beats", 32'(d2_out_beats), 32'd2);
        step(2'b00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/width_gather.md
Name: width_gather

Overview:
- Receive side of the narrow-to-wide bus pair used in the parameter/defparam regression benchmarks.
- Accepts width1-bit beats over a valid/ready handshake and packs consecutive beats into width2-bit words, first beat in the least significant slice.
- Holds one completed word in an output register while the next word collects; supports early flush with zero padding.
- Parameters are overridable by both instance parameter assignment and defparam from a parent module.

Parameters:
- width1, 2, input beat width in bits.
- width2, 8, output word width in bits; must be an integer multiple of width1.
- beats, 4, beats per word; must equal width2/width1.
- cnt_w, 3, counter width; 2**cnt_w must exceed beats.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  width1  incoming beat.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a beat this cycle.
- flush  input  1  emit the partial word now.
- out_data  output  width2  assembled word.
- out_beats  output  cnt_w  number of valid beats in out_data (1..beats).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes out_data this cycle.

Behaviour:
- Internal state: accumulator acc[width2], counter cnt (0..beats), output register (out_data, out_beats, out_valid).
- Reset (sampled at clk edge): acc=0, cnt=0, out_data=0, out_beats=0, out_valid=0. in_ready=0 while reset is high.
- in_ready = !reset && (cnt < beats), combinational from registers only.
- Beat accepted when in_valid && in_ready. The beat is written to acc[cnt*width1 +: width1] and cnt increments.
- The output slot is free in a cycle when !out_valid || out_ready.
- Word complete in cycle T when one of the following holds:
  - the last beat is accepted (cnt==beats-1);
  - cnt==beats from an earlier stall;
  - a flush is taken.
- Complete word and slot free in T: out_data <= acc (including the beat accepted in T), out_beats <= beat count, out_valid=1 in T+1. acc <= 0, cnt <= 0.
- Complete word but slot busy: cnt holds at beats, so in_ready=0. Transfer occurs in the first cycle the slot is free. in_ready rises the cycle after the transfer.
- Latency: out_valid rises 1 cycle after the last beat is accepted (slot free). Throughput: one word per beats cycles with no bubbles.
- Consume and refill in the same cycle: out_valid stays 1 and out_data takes the new word.
- Consume only: out_valid falls next cycle. out_data keeps its last value.
- While out_valid && !out_ready, out_data and out_beats are stable.
- Flush semantics:
  - Taken only when (cnt>0 or a beat is accepted in the same cycle) and cnt<beats.
  - Same-cycle beat is included first.
  - Unfilled upper slices are zero.
  - If the slot is busy, the word is latched as complete (cnt forced to beats internally, with the true beat count retained for out_beats) and emitted when the slot frees.
  - Flush with cnt==0 and no beat: ignored.
  - Flush when cnt==beats: no effect.
- Reset mid-word or mid-stall discards acc and the output register. No partial word is ever emitted after reset.
- No internal state machine beyond the cnt and out_valid registers. The implicit states are COLLECT (cnt<beats), STALL (cnt==beats), and OUT_FULL/OUT_EMPTY.

Test Plan:
1. Assert reset 2 cycles, then release -> out_valid=0, out_data=0x00, out_beats=0, in_ready=1 on the first cycle after reset; in_ready=0 while reset is high.
2. out_ready=1; beats 2'b01, 2'b10, 2'b11, 2'b00 on consecutive cycles -> one cycle after the 4th beat: out_valid=1, out_data=0x39, out_beats=4. in_ready stays 1 throughout. A second word 0xE4 streamed back-to-back appears exactly 4 cycles later.
3. out_ready=0; send words 0x39 then 0xE4 -> 0x39 is held stable; after the 8th beat in_ready=0. Raise out_ready for 1 cycle -> 0x39 consumed, 0xE4 valid next cycle, in_ready=1 the cycle after the transfer.
4. Beats 2'b11, 2'b01, then flush alone -> out_data=0x07, out_beats=2. Separately: 2 beats plus a third beat 2'b10 with flush in the same cycle -> out_data=0x27, out_beats=3.
5. Send 3 beats, pulse reset, then 4 beats 2'b00, 2'b01, 2'b10, 2'b11 -> a single word 0xE4 with out_beats=4. No word is emitted from the pre-reset beats.
6. Parent module with defparam setting width1=4, width2=8, beats=2; beats 4'hA, 4'h5 -> out_data=0x5A, out_valid 1 cycle after the 2nd beat, out_beats=2.
